decode_stage: RTL
=================

# decode_stage

Instruction decode stage sitting directly upstream of the ALU. Accepts one RV32I integer instruction per cycle from fetch, drives register-file read addresses, and forms the ALU operand pair and 4-bit operation code. It tracks in-flight destination registers in a busy scoreboard, stalling fetch on read-after-write hazards until writeback clears them. All outputs toward the ALU are registered, so `OP_VAL`/`A`/`B` arrive one cycle after acceptance.

## Interface
- No parameters; XLEN fixed at 32, register file fixed at 32 entries.
- `CK_REF` in 1 — single clock, rising edge.
- `RST_N` in 1 — asynchronous, active-low reset.
- `INSTR` in 32 — instruction word from fetch.
- `INSTR_VALID` in 1 — `INSTR` is valid this cycle.
- `INSTR_READY` out 1 — decode accepts `INSTR` this cycle (combinational).
- `FLUSH` in 1 — discard the instruction presented this cycle.
- `RS1_ADDR`, `RS2_ADDR` out 5 — combinational `INSTR[19:15]`, `INSTR[24:20]`.
- `RS1_DATA`, `RS2_DATA` in 32 — register-file read data, same cycle.
- `WB_EN` in 1 — writeback strobe from the stage after the ALU.
- `WB_ADDR` in 5 — writeback destination register.
- `WB_DATA` in 32 — writeback value.
- `OP_VAL` out 4 — ALU op code (registered).
- `A`, `B` out 32 — ALU operands (registered).
- `RD_ADDR` out 5 — destination register travelling with the op (registered).
- `DEC_VALID` out 1 — the registered outputs carry a real op.
- `ILLEGAL` out 1 — one-cycle pulse when an unsupported encoding is consumed.

## Operation
- **Op codes:**
  - 0001 add, 0010 sub, 0011 slt, 1011 sltu.
  - 0100 and, 0101 or, 0110 xor.
  - 0111 sll, 1000 srl, 1001 sra.
  - 0000 is a bubble; the ALU treats it as no-op.
- **Accept:** when `INSTR_VALID && INSTR_READY && !FLUSH`.
- **OP (0110011):**
  - funct7 0000000 selects add/sll/slt/sltu/xor/srl/or/and by funct3.
  - funct7 0100000 with funct3 000 is sub; with funct3 101 is sra.
  - `A`=rs1 value, `B`=rs2 value.
- **OP-IMM (0010011):**
  - addi/slti/sltiu/xori/ori/andi: `B` = sign-extended `INSTR[31:20]`.
  - slli/srli/srai: `B` = {27'b0, `INSTR[24:20]`}; funct7 must be 0000000, or 0100000 for srai.
- **LUI (0110111):** `OP_VAL`=0001, `A`=0, `B`={`INSTR[31:12]`, 12'b0}, rs1/rs2 unused.
- **Register x0:** source x0 reads as 0 regardless of `RS*_DATA`.
- **Operand bypass:** if `WB_EN` and `WB_ADDR`==rs≠0 in the accept cycle, `WB_DATA` replaces `RS*_DATA`.
- **Illegal encodings:** any other opcode or funct combination is consumed (`INSTR_READY`=1), issues a bubble, and pulses `ILLEGAL` on the registered cycle.
- **Scoreboard:** 32-bit busy vector.
  - Set bit rd on accept of a legal op with rd≠0.
  - Clear bit `WB_ADDR` on `WB_EN`.
  - Same register set and cleared in one cycle: set wins.
  - Bit 0 is never set.
- **Hazard:** a used source rs≠0 has its busy bit set and is not being cleared this cycle.
  - `INSTR_READY`=0 while a hazard exists.
  - A bubble is issued each stalled cycle.
- **FLUSH:** drops the presented instruction.
  - No busy set and no `ILLEGAL`; a bubble is issued.
  - Busy bits of already-issued ops are untouched.

## Timing
- **Reset values:** `OP_VAL`=0, `A`=0, `B`=0, `RD_ADDR`=0, `DEC_VALID`=0, `ILLEGAL`=0, busy=0.
- **`INSTR_READY` in reset:** 1 while `RST_N` is low.
- **Reset mid-operation:** clears the scoreboard immediately; pending writebacks after reset release are ignored by busy logic (clear of a 0 bit).
- **Latency:** accept in cycle N → outputs valid in cycle N+1. Downstream never stalls; a new op or bubble is registered every cycle.
- **Hazard release:** `WB_EN` cycle N on the blocking register → `INSTR_READY`=1 in cycle N, accepted with bypassed data, outputs in N+1.
- **Fetch handshake:** must hold `INSTR` stable while `INSTR_VALID && !INSTR_READY`.
- **`INSTR_VALID`=0:** a bubble is issued.

## Test plan
- **Reset:** assert `RST_N`=0 mid-stream → all outputs 0, busy cleared, `INSTR_READY`=1; first op after release issues without stall.
- **Register-register add:** `INSTR`=0x002081B3 (add x3,x1,x2), `RS1_DATA`=5, `RS2_DATA`=7 → next cycle `OP_VAL`=0001, `A`=5, `B`=7, `RD_ADDR`=3, `DEC_VALID`=1.
- **Shift immediate:** `INSTR`=0x40435293 (srai x5,x6,4), `RS1_DATA`=0x8000_0000 → `OP_VAL`=1001, `A`=0x8000_0000, `B`=4, `RD_ADDR`=5.
- **Sign extension and x0:** `INSTR`=0xFFF00093 (addi x1,x0,-1), `RS1_DATA`=0x1234 → `OP_VAL`=0001, `A`=0, `B`=0xFFFF_FFFF.
- **RAW hazard:**
  - Stimulus: add x3 accepted, then sub x4,x3,x1 (0x40118233) held valid.
  - Stall: `INSTR_READY`=0 with bubbles.
  - Release: `WB_EN`=1, `WB_ADDR`=3, `WB_DATA`=9, `RS2`/x1 data=2 → accepted that cycle; next cycle `OP_VAL`=0010, `A`=9, `B`=2.
- **Illegal and flush:**
  - `INSTR`=0x0000_0000 → `ILLEGAL` pulses 1 cycle, `DEC_VALID`=0, `OP_VAL`=0.
  - add x3 with `FLUSH`=1 → bubble, busy[3] stays 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I integer decode in front of the ALU, with a busy scoreboard that stalls fetch on RAW hazards.
// Latency: 1 cycle from accept to registered OP_VAL/A/B/RD_ADDR/DEC_VALID/ILLEGAL.
// Backpressure: INSTR_READY drops while a used source is busy; a bubble is issued every non-accept cycle.
module decode_stage (
    input  logic        CK_REF,
    input  logic        RST_N,
    input  logic [31:0] INSTR,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic        FLUSH,
    output logic [4:0]  RS1_ADDR,
    output logic [4:0]  RS2_ADDR,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    input  logic        WB_EN,
    input  logic [4:0]  WB_ADDR,
    input  logic [31:0] WB_DATA,
    output logic [3:0]  OP_VAL,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  RD_ADDR,
    output logic        DEC_VALID,
    output logic        ILLEGAL
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    typedef enum logic [1:0] {
        BSRC_RS2   = 2'd0,
        BSRC_IMM_I = 2'd1,
        BSRC_SHAMT = 2'd2,
        BSRC_IMM_U = 2'd3
    } bsrc_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] op;
        logic       use_rs1;
        logic       use_rs2;
        bsrc_e      b_src;
    } dec_t;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = INSTR[6:0];
    assign rd     = INSTR[11:7];
    assign funct3 = INSTR[14:12];
    assign rs1    = INSTR[19:15];
    assign rs2    = INSTR[24:20];
    assign funct7 = INSTR[31:25];

    assign RS1_ADDR = rs1;
    assign RS2_ADDR = rs2;

    dec_t dec;

    always_comb begin
        dec = '{legal: 1'b0, op: ALU_NOP, use_rs1: 1'b0, use_rs2: 1'b0, b_src: BSRC_RS2};
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec.legal = 1'b1;
                    case (funct3)
                        3'b000:  dec.op = ALU_ADD;
                        3'b001:  dec.op = ALU_SLL;
                        3'b010:  dec.op = ALU_SLT;
                        3'b011:  dec.op = ALU_SLTU;
                        3'b100:  dec.op = ALU_XOR;
                        3'b101:  dec.op = ALU_SRL;
                        3'b110:  dec.op = ALU_OR;
                        default: dec.op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.legal = 1'b1;
                    dec.op    = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.legal = 1'b1;
                    dec.op    = ALU_SRA;
                end
                dec.use_rs1 = dec.legal;
                dec.use_rs2 = dec.legal;
                dec.b_src   = BSRC_RS2;
            end
            OPC_IMM: begin
                dec.b_src = BSRC_IMM_I;
                case (funct3)
                    3'b000: begin dec.legal = 1'b1; dec.op = ALU_ADD;  end
                    3'b010: begin dec.legal = 1'b1; dec.op = ALU_SLT;  end
                    3'b011: begin dec.legal = 1'b1; dec.op = ALU_SLTU; end
                    3'b100: begin dec.legal = 1'b1; dec.op = ALU_XOR;  end
                    3'b110: begin dec.legal = 1'b1; dec.op = ALU_OR;   end
                    3'b111: begin dec.legal = 1'b1; dec.op = ALU_AND;  end
                    3'b001: begin
                        dec.b_src = BSRC_SHAMT;
                        if (funct7 == F7_BASE) begin
                            dec.legal = 1'b1;
                            dec.op    = ALU_SLL;
                        end
                    end
                    default: begin
                        dec.b_src = BSRC_SHAMT;
                        if (funct7 == F7_BASE) begin
                            dec.legal = 1'b1;
                            dec.op    = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec.legal = 1'b1;
                            dec.op    = ALU_SRA;
                        end
                    end
                endcase
                dec.use_rs1 = dec.legal;
            end
            OPC_LUI: begin
                dec.legal = 1'b1;
                dec.op    = ALU_ADD;
                dec.b_src = BSRC_IMM_U;
            end
            default: ;
        endcase
        if (!dec.legal) begin
            dec.op = ALU_NOP;
        end
    end

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    logic wb_hit1;
    logic wb_hit2;
    logic hazard1;
    logic hazard2;
    logic accept;
    logic issue;

    // A writeback landing this cycle both releases the hazard and supplies the operand.
    assign wb_hit1 = WB_EN && (WB_ADDR == rs1) && (rs1 != 5'd0);
    assign wb_hit2 = WB_EN && (WB_ADDR == rs2) && (rs2 != 5'd0);

    assign hazard1 = dec.use_rs1 && (rs1 != 5'd0) && busy_q[rs1] && !wb_hit1;
    assign hazard2 = dec.use_rs2 && (rs2 != 5'd0) && busy_q[rs2] && !wb_hit2;

    assign INSTR_READY = !(hazard1 || hazard2);
    assign accept      = INSTR_VALID && INSTR_READY && !FLUSH;
    assign issue       = accept && dec.legal;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] a_val;
    logic [31:0] b_val;

    always_comb begin
        rs1_val = 32'd0;
        if (rs1 != 5'd0) begin
            rs1_val = wb_hit1 ? WB_DATA : RS1_DATA;
        end
        rs2_val = 32'd0;
        if (rs2 != 5'd0) begin
            rs2_val = wb_hit2 ? WB_DATA : RS2_DATA;
        end
        a_val = dec.use_rs1 ? rs1_val : 32'd0;
        case (dec.b_src)
            BSRC_RS2:   b_val = rs2_val;
            BSRC_IMM_I: b_val = {{20{INSTR[31]}}, INSTR[31:20]};
            BSRC_SHAMT: b_val = {27'd0, INSTR[24:20]};
            default:    b_val = {INSTR[31:12], 12'd0};
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (WB_EN) begin
            busy_d[WB_ADDR] = 1'b0;
        end
        if (issue && rd != 5'd0) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic        dec_valid_q;
    logic        illegal_q;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            busy_q      <= 32'd0;
            op_q        <= ALU_NOP;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            rd_q        <= 5'd0;
            dec_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            op_q        <= issue ? dec.op : ALU_NOP;
            a_q         <= issue ? a_val : 32'd0;
            b_q         <= issue ? b_val : 32'd0;
            rd_q        <= issue ? rd : 5'd0;
            dec_valid_q <= issue;
            illegal_q   <= accept && !dec.legal;
        end
    end

    assign OP_VAL    = op_q;
    assign A         = a_q;
    assign B         = b_q;
    assign RD_ADDR   = rd_q;
    assign DEC_VALID = dec_valid_q;
    assign ILLEGAL   = illegal_q;

endmodule
